score_sequencer: RTL and testbench
==================================

// Module: score_sequencer
// PURPOSE
//  Sequences the BCD score counter from playfield line-clear events. Accepts one clear
//  event (1-4 lines) per handshake, converts it to a point count scaled by current level,
//  and emits that many paced single-cycle increment pulses to the score counter.
//  Tracks lines cleared and game level. Sits between the playfield clear logic and the
//  score counter / HEX display path.
// PARAMETERS
//  PACE_CYCLES      4   clock cycles between consecutive inc_pulse (>=1; 1 = back-to-back)
//  LINES_PER_LEVEL  10  lines needed per level-up (>=4)
//  MAX_LEVEL        9   level saturation value (<=15)
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  synchronous active-low reset
//  game_active  in   1  level; high while a game runs, low aborts/clears
//  clr_valid    in   1  clear event valid
//  clr_lines    in   3  lines cleared in event; 1..4 legal
//  clr_ready    out  1  event accepted on clk edge when clr_valid && clr_ready
//  inc_pulse    out  1  one-cycle increment request to score counter (+1 point)
//  score_clear  out  1  one-cycle pulse: zero the score counter
//  busy         out  1  high while pulses remain to be emitted
//  level        out  4  current level 0..MAX_LEVEL
// BEHAVIOUR
//  Reset: clr_ready=0, inc_pulse=0, score_clear=0, busy=0, level=0, line count=0,
//   remaining=0, pace counter=0, state IDLE. All outputs registered.
//  clr_ready = game_active && state==IDLE && !score_clear (combinational from regs).
//  Points: base(1)=1, base(2)=3, base(3)=5, base(4)=8; points = base*(level+1),
//   using level BEFORE this event's update; max 8*16=128 -> 8-bit remaining counter.
//  clr_lines 0 or 5..7: event accepted, no pulses, no line/level change, stays IDLE.
//  States: IDLE -> EMIT on legal accept; EMIT -> IDLE when last pulse emitted.
//  Accept at edge N: remaining=points, busy=1 from cycle N+1, inc_pulse high in cycle
//   N+1; further pulses every PACE_CYCLES cycles; each pulse decrements remaining.
//   Edge ending the last pulse cycle: state IDLE, busy=0; clr_ready high next cycle.
//  Level: line count += clr_lines at accept; if result >= LINES_PER_LEVEL, subtract
//   LINES_PER_LEVEL and level+1, saturating at MAX_LEVEL (line count still wraps).
//  score_clear: pulses one cycle after game_active rising edge (0->1 sampled) and in the
//   first cycle after resetn deasserts; no event accepted while score_clear=1.
//  game_active low (any state, mid-emission included): next edge -> IDLE, remaining=0,
//   inc_pulse=0, busy=0, level=0, line count=0. Pending points are discarded.
//  resetn low mid-emission: same as reset; no partial pulse.
//  clr_valid while busy: clr_ready=0, producer holds event (valid/ready, no drop).
// STRUCTURE
//  Package tetris_score_pkg: state enum {IDLE,EMIT}, base-points function
//   (lines->4-bit), MAX_LINES_EVENT=4 constant.
//  Sub-module pulse_pacer: down-counter that fires a strobe every PACE_CYCLES cycles
//   while enabled, restarts to fire immediately on load; top holds FSM and level.
// TESTING
//  1. Reset, game_active 0->1 -> score_clear one pulse; clr_ready=1 following cycle.
//  2. level 0, clr_lines=1 -> exactly 1 inc_pulse in cycle after accept, busy 1 cycle.
//  3. level 0, clr_lines=4, PACE_CYCLES=4 -> 8 pulses at cycles +1,+5,..,+29; clr_ready low
//     throughout; second valid event held until busy=0, then accepted.
//  4. Three 4-line clears -> level 0->1 after the third (12 lines, count=2); fourth
//     clear of 2 lines -> 3*2=6 pulses. Drive to level 9, more clears -> level stays 9.
//  5. game_active drop mid-emission of 40-point event -> inc_pulse 0 next cycle, busy 0,
//     level 0; total pulses < 40.
//  6. clr_lines=0 and 6 -> accepted, zero pulses, level/line count unchanged.

Source files
------------

// File: rtl/tetris_score_pkg.sv
// Package: tetris_score_pkg
// Shared types and helpers for the score sequencer slice.
//   state_t          - sequencer state (IDLE waits for a clear event, EMIT paces pulses)
//   MAX_LINES_EVENT  - most lines a single clear event can report
//   base_points()    - base point value of a clear event, before level scaling
//   lines_legal()    - true when a clear event reports 1..MAX_LINES_EVENT lines
package tetris_score_pkg;

  localparam int MAX_LINES_EVENT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [3:0] base_points(input logic [2:0] lines);
    logic [3:0] pts;
    case (lines)
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      3'd4:    pts = 4'd8;
      default: pts = 4'd0;
    endcase
    return pts;
  endfunction

  function automatic logic lines_legal(input logic [2:0] lines);
    return (lines != 3'd0) && (lines <= 3'(MAX_LINES_EVENT));
  endfunction

endpackage

// File: rtl/score_sequencer_pulse_pacer.sv
// Module: pulse_pacer
// Registered strobe generator. A load makes the strobe fire in the very next cycle;
// while enabled it then fires once every PACE_CYCLES cycles. Dropping enable
// silences the strobe on the next edge and parks the counter at zero.
// Ports:
//   clk     in  system clock
//   resetn  in  synchronous active-low reset
//   load    in  start a new pulse train (fires next cycle)
//   enable  in  keep the current pulse train running
//   strobe  out registered one-cycle strobe
module pulse_pacer #(
  parameter int PACE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic enable,
  output logic strobe
);

  localparam int CW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PACE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (load) begin
      cnt    <= RELOAD;
      strobe <= 1'b1;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt    <= RELOAD;
        strobe <= 1'b1;
      end else begin
        cnt    <= cnt - 1'b1;
        strobe <= 1'b0;
      end
    end else begin
      cnt    <= '0;
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Module: score_sequencer
// Turns playfield line-clear events into paced +1 increment pulses for the BCD
// score counter, scaling points by the current level, and tracks lines/level.
// Ports:
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   game_active  in   high while a game runs; low aborts emission and clears level
//   clr_valid    in   clear event valid
//   clr_lines    in   lines cleared (1..4 legal; others accepted and ignored)
//   clr_ready    out  event accepted on an edge where clr_valid && clr_ready
//   inc_pulse    out  one-cycle +1 request to the score counter
//   score_clear  out  one-cycle request to zero the score counter
//   busy         out  high while pulses remain to be emitted
//   level        out  current level, saturating at MAX_LEVEL
module score_sequencer
  import tetris_score_pkg::*;
#(
  parameter int PACE_CYCLES     = 4,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       game_active,
  input  logic       clr_valid,
  input  logic [2:0] clr_lines,
  output logic       clr_ready,
  output logic       inc_pulse,
  output logic       score_clear,
  output logic       busy,
  output logic [3:0] level
);

  // Line count never exceeds LINES_PER_LEVEL-1 at rest, plus one event's worth on add.
  localparam int LW  = $clog2(LINES_PER_LEVEL + MAX_LINES_EVENT);
  localparam int LSW = LW + 1;
  localparam logic [LSW-1:0] LINES_WRAP = LSW'(LINES_PER_LEVEL);
  localparam logic [3:0]     LEVEL_CAP  = 4'(MAX_LEVEL);

  state_t          state;
  logic [7:0]      remaining;
  logic [LW-1:0]   line_cnt;
  logic            game_active_q;
  logic            post_reset;

  logic            accept;
  logic            legal;
  logic            last_pulse;
  logic            pacer_load;
  logic            pacer_en;
  logic [LSW-1:0]  line_sum;
  logic [7:0]      points;

  assign clr_ready  = game_active && (state == IDLE) && !score_clear;
  assign accept     = clr_valid && clr_ready;
  assign legal      = lines_legal(clr_lines);
  // Level before this event's update scales the points; 8*16 = 128 fits in 8 bits.
  assign points     = 8'(base_points(clr_lines)) * 8'({1'b0, level} + 5'd1);
  assign line_sum   = {1'b0, line_cnt} + LSW'(clr_lines);
  assign last_pulse = inc_pulse && (remaining == 8'd1);
  assign pacer_load = accept && legal;
  // Stop the pacer on the edge that ends the final pulse so PACE_CYCLES=1 cannot overrun.
  assign pacer_en   = game_active && (state == EMIT) && !last_pulse;

  pulse_pacer #(
    .PACE_CYCLES (PACE_CYCLES)
  ) u_pacer (
    .clk    (clk),
    .resetn (resetn),
    .load   (pacer_load),
    .enable (pacer_en),
    .strobe (inc_pulse)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      remaining     <= '0;
      level         <= '0;
      line_cnt      <= '0;
      game_active_q <= 1'b0;
      score_clear   <= 1'b0;
      post_reset    <= 1'b1;
    end else begin
      game_active_q <= game_active;
      post_reset    <= 1'b0;
      score_clear   <= post_reset || (game_active && !game_active_q);

      if (!game_active) begin
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
        level     <= '0;
        line_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && legal) begin
              state     <= EMIT;
              busy      <= 1'b1;
              remaining <= points;
              if (line_sum >= LINES_WRAP) begin
                line_cnt <= LW'(line_sum - LINES_WRAP);
                if (level != LEVEL_CAP) level <= level + 4'd1;
              end else begin
                line_cnt <= LW'(line_sum);
              end
            end
          end
          EMIT: begin
            if (inc_pulse) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Testbench: tb_score_sequencer
// Drives clear events into score_sequencer and compares pulse counts, pulse
// spacing, busy duration and level against a game-level model: total lines since
// the game started, level = min(MAX_LEVEL, total / LINES_PER_LEVEL), and
// points = base(lines) * (level_before + 1).
module tb_score_sequencer;

  localparam int PACE = 4;
  localparam int LPL  = 10;
  localparam int MAXL = 9;

  logic       clk = 1'b0;
  logic       resetn;
  logic       game_active;
  logic       clr_valid;
  logic [2:0] clr_lines;
  logic       clr_ready;
  logic       inc_pulse;
  logic       score_clear;
  logic       busy;
  logic [3:0] level;

  score_sequencer #(
    .PACE_CYCLES     (PACE),
    .LINES_PER_LEVEL (LPL),
    .MAX_LEVEL       (MAXL)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .game_active (game_active),
    .clr_valid   (clr_valid),
    .clr_lines   (clr_lines),
    .clr_ready   (clr_ready),
    .inc_pulse   (inc_pulse),
    .score_clear (score_clear),
    .busy        (busy),
    .level       (level)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Cycle-level observers, sampled on the falling edge.
  int cyc            = 0;
  int pulse_total    = 0;
  int last_pulse_cyc = -1;
  int gap_errors     = 0;
  int ready_busy     = 0;
  int stray_pulses   = 0;
  int p0             = 0;
  int g0             = 0;

  always @(negedge clk) begin
    cyc++;
    if (inc_pulse === 1'b1) begin
      if (last_pulse_cyc >= 0 && (cyc - last_pulse_cyc) != PACE) gap_errors++;
      last_pulse_cyc = cyc;
      pulse_total++;
      if (busy !== 1'b1) stray_pulses++;
    end
    if (busy === 1'b1 && clr_ready === 1'b1) ready_busy++;
  end

  // Game-level reference model.
  int m_lines = 0;

  function automatic int base_of(input int lines);
    case (lines)
      1:       return 1;
      2:       return 3;
      3:       return 5;
      4:       return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int m_level();
    int l;
    l = m_lines / LPL;
    return (l > MAXL) ? MAXL : l;
  endfunction

  // Returns expected points for an event and folds its lines into the model.
  function automatic int m_event(input int lines);
    int pts;
    pts = base_of(lines) * (m_level() + 1);
    if (lines >= 1 && lines <= 4) m_lines += lines;
    return pts;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offers an event and returns once it has been taken (one tick after the accepting edge).
  task automatic handshake(input int lines, output bit acc);
    acc       = 1'b0;
    clr_valid = 1'b1;
    clr_lines = 3'(lines);
    for (int i = 0; i < 64; i++) begin
      if (clr_ready === 1'b1) begin
        last_pulse_cyc = -1;
        p0 = pulse_total;
        g0 = gap_errors;
        tick();
        acc = 1'b1;
        break;
      end
      tick();
    end
    clr_valid = 1'b0;
    clr_lines = 3'($urandom_range(0, 7));
  endtask

  task automatic run_event(input int lines, input int exp_p, input int exp_lvl, input string tag);
    bit acc;
    int n;
    handshake(lines, acc);
    check($sformatf("%s accept", tag), acc, 1);
    if (!acc) return;
    check($sformatf("%s first pulse", tag), inc_pulse, (exp_p > 0) ? 1 : 0);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check($sformatf("%s busy cycles", tag), n, (exp_p > 0) ? (exp_p - 1) * PACE + 1 : 0);
    check($sformatf("%s pulses", tag), pulse_total - p0, exp_p);
    check($sformatf("%s spacing", tag), gap_errors - g0, 0);
    check($sformatf("%s level", tag), level, exp_lvl);
    check($sformatf("%s ready after", tag), clr_ready, 1);
  endtask

  task automatic new_game();
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    tick();
    check("new game score_clear", score_clear, 1);
    check("new game ready blocked", clr_ready, 0);
    tick();
    check("new game score_clear end", score_clear, 0);
    check("new game ready", clr_ready, 1);
    m_lines = 0;
  endtask

  typedef struct {
    int lines;
    int pulses;
    int lvl;
  } vec_t;

  vec_t table_v[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, first_cyc, last, exp_p, w, l;

    // Events from a fresh game: {lines, pulses, level after}.
    table_v[0]  = '{1, 1, 0};
    table_v[1]  = '{4, 8, 0};
    table_v[2]  = '{4, 8, 0};
    table_v[3]  = '{0, 0, 0};
    table_v[4]  = '{6, 0, 0};
    table_v[5]  = '{2, 3, 1};
    table_v[6]  = '{3, 10, 1};
    table_v[7]  = '{4, 16, 1};
    table_v[8]  = '{2, 6, 2};
    table_v[9]  = '{1, 3, 2};
    table_v[10] = '{7, 0, 2};
    table_v[11] = '{3, 15, 2};

    resetn      = 1'b0;
    game_active = 1'b0;
    clr_valid   = 1'b0;
    clr_lines   = 3'd0;

    // Reset values and score_clear after reset release / game start.
    repeat (3) tick();
    check("reset clr_ready", clr_ready, 0);
    check("reset inc_pulse", inc_pulse, 0);
    check("reset score_clear", score_clear, 0);
    check("reset busy", busy, 0);
    check("reset level", level, 0);
    resetn = 1'b1;
    tick();
    check("post-reset score_clear", score_clear, 1);
    tick();
    check("post-reset score_clear end", score_clear, 0);
    check("idle game ready", clr_ready, 0);
    new_game();

    // Table-driven events including illegal line counts.
    for (int i = 0; i < 12; i++)
      run_event(table_v[i].lines, table_v[i].pulses, table_v[i].lvl, $sformatf("table%0d", i));

    // 4-line clear paced every PACE cycles; a second event is held until busy drops.
    new_game();
    handshake(4, acc);
    check("t3 accept", acc, 1);
    first_cyc = cyc;
    check("t3 first pulse", inc_pulse, 1);
    clr_valid = 1'b1;
    clr_lines = 3'd1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("t3 pulses", pulse_total - p0, 8);
    check("t3 last pulse offset", last_pulse_cyc - first_cyc, 28);
    check("t3 ready after busy", clr_ready, 1);
    last = last_pulse_cyc;
    last_pulse_cyc = -1;
    tick();
    clr_valid = 1'b0;
    check("t3 held event pulse", inc_pulse, 1);
    check("t3 held event timing", cyc - last, 2);
    tick();
    check("t3 held event busy", busy, 0);
    check("t3 level", level, 0);

    // Level-up on the third 4-line clear, then climb to saturation.
    new_game();
    run_event(4, 8, 0, "t4 a");
    run_event(4, 8, 0, "t4 b");
    run_event(4, 8, 1, "t4 c");
    run_event(2, 6, 1, "t4 d");
    m_lines = 14;
    for (int k = 0; k < 26; k++) begin
      exp_p = m_event(4);
      run_event(4, exp_p, m_level(), "t4 climb");
    end
    check("t4 saturated level", level, MAXL);
    exp_p = m_event(3);
    run_event(3, exp_p, MAXL, "t4 saturated 3-line");
    check("t4 saturated points", exp_p, 50);

    // Abort mid-emission of a 40-point event.
    new_game();
    for (int k = 0; k < 10; k++) begin
      exp_p = m_event(4);
      run_event(4, exp_p, m_level(), "t5 setup");
    end
    check("t5 level 4", level, 4);
    handshake(4, acc);
    check("t5 accept", acc, 1);
    n = 0;
    while ((pulse_total - p0) < 10 && n < 200) begin
      n++;
      tick();
    end
    check("t5 reached 10 pulses", pulse_total - p0, 10);
    game_active = 1'b0;
    tick();
    check("t5 inc_pulse after abort", inc_pulse, 0);
    check("t5 busy after abort", busy, 0);
    check("t5 level after abort", level, 0);
    w = pulse_total;
    repeat (8) tick();
    check("t5 no pulses after abort", pulse_total - w, 0);
    check("t5 fewer than 40", (pulse_total - p0) < 40, 1);
    new_game();
    run_event(4, 8, 0, "t5 restarted");
    m_lines = 4;

    // Reset mid-emission.
    handshake(3, acc);
    check("rst accept", acc, 1);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    check("rst inc_pulse", inc_pulse, 0);
    check("rst busy", busy, 0);
    check("rst level", level, 0);
    check("rst score_clear", score_clear, 0);
    w = pulse_total;
    tick();
    resetn = 1'b1;
    tick();
    check("rst release score_clear", score_clear, 1);
    tick();
    check("rst release ready", clr_ready, 1);
    check("rst no partial pulse", pulse_total - w, 0);
    m_lines = 0;
    run_event(2, 3, 0, "rst follow-up");
    m_lines = 2;

    // Randomized events against the model, with occasional aborts.
    new_game();
    for (int e = 0; e < 60; e++) begin
      if ($urandom_range(0, 4) == 0) l = $urandom_range(0, 7);
      else l = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) tick();
      exp_p = m_event(l);
      if (exp_p > 1 && $urandom_range(0, 9) == 0) begin
        handshake(l, acc);
        check("rand abort accept", acc, 1);
        w = $urandom_range(0, (exp_p - 1) * PACE - 1);
        repeat (w) tick();
        game_active = 1'b0;
        tick();
        check("rand abort inc_pulse", inc_pulse, 0);
        check("rand abort busy", busy, 0);
        check("rand abort level", level, 0);
        check("rand abort partial", (pulse_total - p0) < exp_p, 1);
        new_game();
      end else begin
        run_event(l, exp_p, m_level(), "rand");
      end
    end

    check("ready never high while busy", ready_busy, 0);
    check("no pulse outside busy", stray_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
